// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register.
// Grants one requester at a time and owns the register's load and reset.
module shared_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  ck,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  wr_done,
  output logic [IDW-1:0]        owner,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    HOLD
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_n;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  sel_n;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  owner_n;
  logic [NREQ-1:0] gnt_n;
  logic [WIDTH-1:0] q_n;
  logic            wr_done_n;
  logic            found;
  logic [WIDTH-1:0] slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = wdata[i*WIDTH +: WIDTH];
  end

  assign busy = (state != IDLE);

  // First pending request scanning upward from ptr, wrapping at NREQ
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(ptr) + k) % NREQ;
      idx_w = IDW'(idx);
      if (!found && req[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic for the grant sequence
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    gnt_n     = gnt;
    q_n       = q;
    owner_n   = owner;
    wr_done_n = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_n = '0;
        if (found) begin
          sel_n       = pick;
          gnt_n[pick] = 1'b1;
          state_n     = WRITE;
        end
      end
      WRITE: begin
        q_n       = slice[sel];
        owner_n   = sel;
        wr_done_n = 1'b1;
        state_n   = HOLD;
      end
      HOLD: begin
        if (!req[sel]) begin
          gnt_n = '0;
          if (int'(sel) == NREQ - 1) ptr_n = '0;
          else ptr_n = sel + 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State register; reset aborts any pending write
  always_ff @(posedge ck) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      sel     <= '0;
      gnt     <= '0;
      q       <= '0;
      owner   <= '0;
      wr_done <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      sel     <= sel_n;
      gnt     <= gnt_n;
      q       <= q_n;
      owner   <= owner_n;
      wr_done <= wr_done_n;
    end
  end

endmodule
